// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
// The default widths match the team multiplier: a 10-bit product divided by its 6-bit operand.
package div_pkg;

    localparam int DIV_WIDTH_N = 10;
    localparam int DIV_WIDTH_D = 6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Width of a down-counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift a dividend bit into the partial remainder, then subtract if it fits.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH_D = DIV_WIDTH_D
) (
    input  logic [WIDTH_D:0]   partial_in,
    input  logic               bit_in,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_D:0]   partial_out,
    output logic               quotient_bit
);

    logic [WIDTH_D+1:0] shifted;
    logic [WIDTH_D:0]   diff;

    assign shifted      = {partial_in, bit_in};
    assign quotient_bit = (shifted >= {2'b00, divisor});
    // The difference always fits in WIDTH_D+1 bits when it is selected, so the top bit can be dropped.
    assign diff         = shifted[WIDTH_D:0] - {1'b0, divisor};
    assign partial_out  = quotient_bit ? diff : shifted[WIDTH_D:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock; a single operation is in flight at a time.
// Latency: out_valid rises WIDTH_N edges after the accepting edge, or on the accepting edge for a zero divisor.
// Backpressure: the result is held in DONE until out_ready; in_ready is only high in IDLE.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH_N = DIV_WIDTH_N,
    parameter int WIDTH_D = DIV_WIDTH_D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH_N);

    div_state_t         state;
    div_state_t         state_nxt;
    logic [WIDTH_D:0]   partial;
    logic [WIDTH_D:0]   partial_nxt;
    logic [WIDTH_N-1:0] work;
    logic [WIDTH_D-1:0] divisor_q;
    logic [CNT_W-1:0]   count;
    logic               q_bit;
    logic               accept;
    logic               last_step;

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == CALC) && (count == CNT_W'(1));

    div_step #(
        .WIDTH_D (WIDTH_D)
    ) u_step (
        .partial_in   (partial),
        .bit_in       (work[WIDTH_N-1]),
        .divisor      (divisor_q),
        .partial_out  (partial_nxt),
        .quotient_bit (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The work register shifts dividend bits out of its top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial     <= '0;
            work        <= '0;
            divisor_q   <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            partial   <= '0;
            work      <= dividend;
            divisor_q <= divisor;
            if (divisor == '0) begin
                count       <= '0;
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else begin
                count <= CNT_W'(WIDTH_N);
            end
        end else if (state == CALC) begin
            partial <= partial_nxt;
            work    <= {work[WIDTH_N-2:0], q_bit};
            count   <= count - CNT_W'(1);
            if (last_step) begin
                quotient    <= {work[WIDTH_N-2:0], q_bit};
                remainder   <= partial_nxt[WIDTH_D-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed vectors for seq_divider; a monitor checks every presented result against a scoreboard queue.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] dividend;
    logic [5:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] quotient;
    logic [5:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [9:0] q;
        logic [5:0] r;
        logic       z;
    } res_t;

    typedef struct {
        logic [9:0] a;
        logic [5:0] b;
        int         lat;
        int         hold;
        logic [9:0] q;
        logic [5:0] r;
        logic       z;
    } vec_t;

    res_t sb[$];
    vec_t vecs[8];

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every cycle a result is presented it must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", sb.size(), 1);
            end else begin
                chk("quotient", quotient, sb[0].q);
                chk("remainder", remainder, sb[0].r);
                chk("div_by_zero", div_by_zero, sb[0].z);
                if (out_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic do_op(input vec_t v);
        int   edges;
        logic ir_bad;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        dividend  = v.a;
        divisor   = v.b;
        in_valid  = 1'b1;
        out_ready = (v.hold == 0);
        sb.push_back('{q: v.q, r: v.r, z: v.z});
        @(posedge clk);
        #1;
        // Garbage held on the inputs while busy must not disturb the operation.
        in_valid = (v.hold > 0);
        dividend = ~v.a;
        divisor  = 6'd1;
        edges    = 0;
        ir_bad   = 1'b0;
        while (!out_valid && edges < 40) begin
            if (in_ready) ir_bad = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency_edges", edges, v.lat);
        chk("in_ready_busy", ir_bad, 0);
        repeat (v.hold) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("out_valid_after_drain", out_valid, 0);
        chk("in_ready_after_drain", in_ready, 1);
        chk("quotient_retained", quotient, v.q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // lat = edges after the accepting edge until out_valid is seen
        vecs[0] = '{a: 10'd15,   b: 6'd3,  lat: 10, hold: 0, q: 10'd5,    r: 6'd0,  z: 1'b0};
        vecs[1] = '{a: 10'd1023, b: 6'd63, lat: 10, hold: 0, q: 10'd16,   r: 6'd15, z: 1'b0};
        vecs[2] = '{a: 10'd1023, b: 6'd1,  lat: 10, hold: 0, q: 10'd1023, r: 6'd0,  z: 1'b0};
        vecs[3] = '{a: 10'd3,    b: 6'd7,  lat: 10, hold: 0, q: 10'd0,    r: 6'd3,  z: 1'b0};
        vecs[4] = '{a: 10'd5,    b: 6'd0,  lat: 0,  hold: 0, q: 10'd1023, r: 6'd0,  z: 1'b1};
        vecs[5] = '{a: 10'd0,    b: 6'd5,  lat: 10, hold: 0, q: 10'd0,    r: 6'd0,  z: 1'b0};
        vecs[6] = '{a: 10'd63,   b: 6'd9,  lat: 10, hold: 5, q: 10'd7,    r: 6'd0,  z: 1'b0};
        vecs[7] = '{a: 10'd1000, b: 6'd7,  lat: 10, hold: 0, q: 10'd142,  r: 6'd6,  z: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i]);
        end

        // Abort 1000/7 during its fourth step.
        @(negedge clk);
        dividend = 10'd1000;
        divisor  = 6'd7;
        in_valid = 1'b1;
        sb.push_back('{q: 10'd142, r: 6'd6, z: 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_abort_quotient", quotient, 7);
        chk("pre_abort_in_ready", in_ready, 0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", in_ready, 1);

        do_op(vecs[7]);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative restoring unsigned divider, the inverse operation of the team's combinational multiplier.
- A product-width dividend is divided by a multiplier-operand-width divisor, one quotient bit per clock.
- Valid/ready handshakes on both input and result sides allow it to sit between pipeline stages or in a datapath that un-scales products.

Parameters:
WIDTH_N, 10, dividend and quotient width (matches multiplier product width 4+6)
WIDTH_D, 6, divisor and remainder width (matches multiplier second operand width)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  dividend/divisor presented
in_ready  output  1  block can accept an operation
dividend  input  WIDTH_N  unsigned dividend
divisor  input  WIDTH_D  unsigned divisor
out_valid  output  1  result registers hold a valid result
out_ready  input  1  consumer accepts the result
quotient  output  WIDTH_N  unsigned quotient
remainder  output  WIDTH_D  unsigned remainder
div_by_zero  output  1  result came from a zero divisor

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset, async on rst_n low:
  - state=IDLE, in_ready=1 (once IDLE), out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0, bit counter=0.
- FSM states IDLE, CALC, DONE. Outputs are registered, with no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the operation is accepted and operands are latched.
  - If divisor==0, go to DONE with quotient=all ones, remainder=0, div_by_zero=1. out_valid is high after 1 edge.
  - Otherwise go to CALC, clear the partial remainder (WIDTH_D+1 bits internal), and load the counter with WIDTH_N.
- CALC:
  - in_ready=0.
  - Each edge does one restoring step:
    - shift {partial, dividend MSB} left;
    - if partial>=divisor, subtract and shift in quotient bit 1, else shift in 0;
    - decrement the counter.
  - After WIDTH_N steps, go to DONE.
  - out_valid rises exactly WIDTH_N edges after the accepting edge (10 at defaults).
- DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder and div_by_zero are held stable while out_ready=0 (arbitrary backpressure).
  - On an edge with out_ready=1, go to IDLE. out_valid falls; result registers keep their values.
  - A new operation cannot be accepted on that same edge: no overlap, single operation in flight.
- Inputs changing while the block is in CALC or DONE have no effect.
- in_valid while in_ready=0 is ignored. The producer holds it; there is no queueing.
- Arithmetic:
  - Unsigned only. dividend == quotient*divisor + remainder, with remainder < divisor.
  - Quotient can reach 2^WIDTH_N-1 (divisor 1).
- Reset mid-CALC or mid-DONE aborts the operation; the result is discarded and the reset values above are restored.
- Throughput: one operation per WIDTH_N+2 cycles at best (accept, WIDTH_N steps, drain).

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  - default width localparams DIV_WIDTH_N=10, DIV_WIDTH_D=6.
- Sub-module div_step (combinational): one restoring iteration.
  - In: partial remainder, next dividend bit, divisor.
  - Out: new partial remainder, quotient bit.
  - Instantiated once in seq_divider and unit-testable on its own.

Test Plan:
- Basic: dividend=15, divisor=3 -> out_valid 10 edges after accept, quotient=5, remainder=0, div_by_zero=0; in_ready=0 throughout.
- Max operands: dividend=1023, divisor=63 -> quotient=16, remainder=15. Dividend 1023, divisor 1 -> quotient=1023, remainder=0.
- Small over large: dividend=3, divisor=7 -> quotient=0, remainder=3.
- Zero divisor: dividend=5, divisor=0 -> out_valid after 1 edge, quotient=1023, remainder=0, div_by_zero=1.
- Backpressure: 63/9 with out_ready=0 for 5 cycles -> quotient=7, remainder=0 held stable; in_valid ignored. out_ready=1 -> IDLE next edge, then accept a new operation.
- Reset mid-CALC: assert rst_n=0 at step 4 of 1000/7 -> outputs zero immediately, in_ready=1 after release. A fresh 1000/7 then yields quotient=142, remainder=6.
